qos_multicanal: RTL

Parametrised flow-control (QoS) controller for the switch datapath, generalising the fixed 4+1 FIFO QoS block to N virtual-channel FIFOs plus one main FIFO. It watches the FIFO status flags and drives per-channel pause/continue requests with hysteresis. It also runs a per-channel starvation watchdog and latches the error cause. It sits between the FIFO bank and the channel arbiters, one instance per switch port.

---
 rtl/qos_multicanal.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/qos_multicanal.sv
// qos_multicanal: flow-control (QoS) controller for N virtual-channel FIFOs
// plus one main FIFO. Drives per-channel pause/resume requests with
// hysteresis, runs a per-channel starvation watchdog and latches the
// cause and the offending FIFOs when it enters the error state.
module qos_multicanal #(
  parameter int N_CANALES = 4,
  parameter int PAUSA_MAX = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enb,
  input  logic                 iniciar_in,
  input  logic [N_CANALES:0]   almost_empty_in,
  input  logic [N_CANALES:0]   almost_full_in,
  input  logic [N_CANALES:0]   full_in,
  input  logic [N_CANALES:0]   empty_in,
  output logic [2:0]           estado_out,
  output logic                 error_out,
  output logic                 idle_out,
  output logic [N_CANALES-1:0] pausa_out,
  output logic [N_CANALES-1:0] continuar_out,
  output logic [1:0]           err_causa_out,
  output logic [N_CANALES:0]   err_canal_out
);

  // Counter is at least one bit wide so PAUSA_MAX=0 (watchdog off) still elaborates.
  localparam int CW = (PAUSA_MAX > 0) ? $clog2(PAUSA_MAX + 1) : 1;
  localparam logic [CW-1:0] WD_MAX  = CW'(PAUSA_MAX);
  localparam logic [CW-1:0] WD_LAST = (PAUSA_MAX > 0) ? CW'(PAUSA_MAX - 1) : CW'(0);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } estado_t;

  estado_t                state_q, state_d;
  logic [N_CANALES-1:0]   pausa_q, pausa_d;
  logic [N_CANALES-1:0]   cont_q, cont_d;
  logic [1:0]             causa_q, causa_d;
  logic [N_CANALES:0]     canal_q, canal_d;
  logic [CW-1:0]          cnt_q [N_CANALES];
  logic [CW-1:0]          cnt_d [N_CANALES];

  logic                   anyFull;
  logic                   enServicio;
  logic                   errEvent;
  logic [N_CANALES-1:0]   wdFire;

  // Watchdog detection and FSM next-state; errors outrank re-init requests.
  always_comb begin
    anyFull    = |full_in;
    enServicio = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    wdFire     = '0;
    for (int i = 0; i < N_CANALES; i++) begin
      wdFire[i] = (PAUSA_MAX != 0) && enServicio && pausa_q[i] && (cnt_q[i] == WD_LAST);
    end
    errEvent = anyFull || (|wdFire);
    state_d  = state_q;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (errEvent)         state_d = ST_ERROR;
        else if (!iniciar_in) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (errEvent)         state_d = ST_ERROR;
        else if (iniciar_in)  state_d = ST_INIT;
        else if (!(&empty_in)) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (errEvent)         state_d = ST_ERROR;
        else if (iniciar_in)  state_d = ST_INIT;
        else if (&empty_in)   state_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (iniciar_in && !anyFull) state_d = ST_INIT;
      end
      default: state_d = ST_RESET;
    endcase
  end

  // Pause flags, resume pulses, watchdog counters and error capture for the next cycle.
  always_comb begin
    pausa_d = pausa_q;
    cont_d  = cont_q;
    causa_d = causa_q;
    canal_d = canal_q;
    cnt_d   = cnt_q;
    if ((state_d == ST_RESET) || (state_d == ST_INIT)) begin
      pausa_d = '0;
      cont_d  = '0;
      causa_d = 2'd0;
      canal_d = '0;
      for (int i = 0; i < N_CANALES; i++) begin
        cnt_d[i] = '0;
      end
    end else if (state_d == ST_ERROR) begin
      pausa_d = '1;
      cont_d  = '0;
      if (state_q != ST_ERROR) begin
        if (anyFull) begin
          causa_d = 2'd1;
          canal_d = full_in;
        end else begin
          causa_d = 2'd2;
          canal_d = {1'b0, wdFire};
        end
      end
    end else if (enServicio) begin
      for (int i = 0; i < N_CANALES; i++) begin
        if (almost_full_in[i] || almost_full_in[N_CANALES]) begin
          pausa_d[i] = 1'b1;
        end else if (almost_empty_in[i] && !almost_full_in[N_CANALES]) begin
          pausa_d[i] = 1'b0;
        end
        cont_d[i] = pausa_q[i] && !pausa_d[i];
        if (!pausa_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] != WD_MAX) begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // State register: reset clears everything, enb=0 freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESET;
      pausa_q <= '0;
      cont_q  <= '0;
      causa_q <= 2'd0;
      canal_q <= '0;
      for (int i = 0; i < N_CANALES; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (enb) begin
      state_q <= state_d;
      pausa_q <= pausa_d;
      cont_q  <= cont_d;
      causa_q <= causa_d;
      canal_q <= canal_d;
      cnt_q   <= cnt_d;
    end
  end

  assign estado_out    = state_q;
  assign error_out     = (state_q == ST_ERROR);
  assign idle_out      = (state_q == ST_IDLE);
  assign pausa_out     = pausa_q;
  assign continuar_out = cont_q;
  assign err_causa_out = causa_q;
  assign err_canal_out = canal_q;

endmodule
